mult_accumulator: RTL and testbench

//   Consumer stage downstream of the repeated-addition multiplier.

---
 rtl/mult_accumulator.sv | 190 +++++++++++++++++++
 tb/tb_mult_accumulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums N_TERMS consecutive multiplier products (each 0->1 edge of
// prod_valid captures one product). The dot-product result goes out on a valid/ready
// handshake. While a result is stalled, one further product can wait in a pending register.
// Optional feature: define MACC_SAT_EN for saturating adds and the acc_sat flag.
// Without it, adds wrap modulo 2^ACC_W and acc_sat is tied low.
module mult_accumulator #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [4:0]       term_cnt,
    output logic             drop_err,
    output logic             acc_sat
);

    typedef enum logic {
        S_ACCUM,
        S_HOLD
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic             prod_valid_q, prod_valid_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [4:0]       term_cnt_q, term_cnt_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             acc_valid_q, acc_valid_d;
    logic             drop_err_q, drop_err_d;
`ifdef MACC_SAT_EN
    logic             sum_sat_q, sum_sat_d;
    logic             acc_sat_q, acc_sat_d;
    logic [ACC_W:0]   sum_wide;
    logic             sat_now;
`endif

    logic             new_prod;
    logic             handshake;
    logic             take;
    logic [7:0]       term;
    logic [ACC_W-1:0] sum_next;

    // Next-state logic: edge detect, accumulate, stall handling and pending-register drain
    always_comb begin
        state_d      = state_q;
        prod_valid_d = prod_valid;
        sum_d        = sum_q;
        term_cnt_d   = term_cnt_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        acc_out_d    = acc_out_q;
        acc_valid_d  = acc_valid_q;
        drop_err_d   = drop_err_q;
`ifdef MACC_SAT_EN
        sum_sat_d    = sum_sat_q;
        acc_sat_d    = acc_sat_q;
        sum_wide     = '0;
        sat_now      = 1'b0;
`endif
        new_prod  = prod_valid && !prod_valid_q;
        handshake = acc_valid_q && acc_ready;
        take      = 1'b0;
        term      = '0;
        sum_next  = '0;

        if (clear) begin
            state_d     = S_ACCUM;
            sum_d       = '0;
            term_cnt_d  = '0;
            pend_d      = '0;
            pend_vld_d  = 1'b0;
            acc_valid_d = 1'b0;
            drop_err_d  = 1'b0;
`ifdef MACC_SAT_EN
            sum_sat_d   = 1'b0;
            acc_sat_d   = 1'b0;
`endif
        end else if (state_q == S_HOLD && !handshake) begin
            if (new_prod) begin
                if (!pend_vld_q) begin
                    pend_d     = prod_in;
                    pend_vld_d = 1'b1;
                end else begin
                    drop_err_d = 1'b1;
                end
            end
        end else begin
            if (handshake) begin
                acc_valid_d = 1'b0;
                state_d     = S_ACCUM;
`ifdef MACC_SAT_EN
                acc_sat_d   = 1'b0;
`endif
            end
            // A waiting pending product is always older than a product arriving now,
            // so it is summed first and the new one takes its place in the register.
            if (pend_vld_q) begin
                take       = 1'b1;
                term       = pend_q;
                pend_vld_d = new_prod;
                if (new_prod) begin
                    pend_d = prod_in;
                end
            end else if (new_prod) begin
                take = 1'b1;
                term = prod_in;
            end

            if (take) begin
`ifdef MACC_SAT_EN
                sum_wide = {1'b0, sum_q} + (ACC_W + 1)'(term);
                sum_next = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
                sat_now  = sum_sat_q || sum_wide[ACC_W];
`else
                sum_next = sum_q + ACC_W'(term);
`endif
                if (term_cnt_q == LAST_CNT) begin
                    acc_out_d   = sum_next;
                    acc_valid_d = 1'b1;
                    sum_d       = '0;
                    term_cnt_d  = '0;
                    state_d     = S_HOLD;
`ifdef MACC_SAT_EN
                    acc_sat_d   = sat_now;
                    sum_sat_d   = 1'b0;
`endif
                end else begin
                    sum_d      = sum_next;
                    term_cnt_d = term_cnt_q + 5'd1;
`ifdef MACC_SAT_EN
                    sum_sat_d  = sat_now;
`endif
                end
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_ACCUM;
            prod_valid_q <= 1'b0;
            sum_q        <= '0;
            term_cnt_q   <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            acc_out_q    <= '0;
            acc_valid_q  <= 1'b0;
            drop_err_q   <= 1'b0;
`ifdef MACC_SAT_EN
            sum_sat_q    <= 1'b0;
            acc_sat_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prod_valid_q <= prod_valid_d;
            sum_q        <= sum_d;
            term_cnt_q   <= term_cnt_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            acc_out_q    <= acc_out_d;
            acc_valid_q  <= acc_valid_d;
            drop_err_q   <= drop_err_d;
`ifdef MACC_SAT_EN
            sum_sat_q    <= sum_sat_d;
            acc_sat_q    <= acc_sat_d;
`endif
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign term_cnt  = term_cnt_q;
    assign drop_err  = drop_err_q;
`ifdef MACC_SAT_EN
    assign acc_sat   = acc_sat_q;
`else
    assign acc_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator. Two instances (ACC_W=12 and ACC_W=9) share one stimulus
// stream and one queue-based reference model. Directed cases come first, then random traffic.
module tb_mult_accumulator;

    logic        clk;
    logic        rst_n;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        clear;
    logic        acc_ready;

    logic [11:0] acc_out;
    logic        acc_valid;
    logic [4:0]  term_cnt;
    logic        drop_err;
    logic        acc_sat;

    logic [8:0]  acc_out9;
    logic        acc_valid9;
    logic [4:0]  term_cnt9;
    logic        drop_err9;
    logic        acc_sat9;

    int checks   = 0;
    int failures = 0;

    mult_accumulator #(.N_TERMS(4), .ACC_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
        .clear(clear), .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .term_cnt(term_cnt), .drop_err(drop_err), .acc_sat(acc_sat)
    );

    mult_accumulator #(.N_TERMS(4), .ACC_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
        .clear(clear), .acc_out(acc_out9), .acc_valid(acc_valid9), .acc_ready(acc_ready),
        .term_cnt(term_cnt9), .drop_err(drop_err9), .acc_sat(acc_sat9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_prev, m_hold, m_cnt, m_drop, m_gsum;
    int m_out12, m_out9, m_sat12, m_sat9;
    int m_pq[$];

    function automatic int fold(input int s, input int w);
        int lim;
        lim = (1 << w) - 1;
`ifdef MACC_SAT_EN
        return (s > lim) ? lim : s;
`else
        return s % (1 << w);
`endif
    endfunction

    function automatic int sat_of(input int s, input int w);
`ifdef MACC_SAT_EN
        return (s > (1 << w) - 1) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int is_new, t, have;
        if (!rst_n) begin
            m_prev = 0; m_hold = 0; m_cnt = 0; m_drop = 0; m_gsum = 0;
            m_out12 = 0; m_out9 = 0; m_sat12 = 0; m_sat9 = 0;
            m_pq.delete();
        end else begin
            is_new = (prod_valid && !m_prev) ? 1 : 0;
            m_prev = prod_valid ? 1 : 0;
            if (clear) begin
                m_hold = 0; m_cnt = 0; m_drop = 0; m_gsum = 0;
                m_sat12 = 0; m_sat9 = 0;
                m_pq.delete();
            end else if (m_hold && !acc_ready) begin
                if (is_new) begin
                    if (m_pq.size() == 0) m_pq.push_back(int'(prod_in));
                    else m_drop = 1;
                end
            end else begin
                if (m_hold) begin
                    m_hold = 0; m_sat12 = 0; m_sat9 = 0;
                end
                have = 0; t = 0;
                if (m_pq.size() != 0) begin
                    t = m_pq.pop_front(); have = 1;
                end
                if (is_new) begin
                    if (have) m_pq.push_back(int'(prod_in));
                    else begin t = int'(prod_in); have = 1; end
                end
                if (have) begin
                    m_gsum += t;
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_out12 = fold(m_gsum, 12); m_sat12 = sat_of(m_gsum, 12);
                        m_out9  = fold(m_gsum, 9);  m_sat9  = sat_of(m_gsum, 9);
                        m_hold = 1; m_gsum = 0; m_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("acc_valid", int'(acc_valid), m_hold);
            chk("term_cnt", int'(term_cnt), m_cnt);
            chk("drop_err", int'(drop_err), m_drop);
            chk("acc_sat", int'(acc_sat), m_sat12);
            chk("acc_valid9", int'(acc_valid9), m_hold);
            chk("term_cnt9", int'(term_cnt9), m_cnt);
            chk("drop_err9", int'(drop_err9), m_drop);
            chk("acc_sat9", int'(acc_sat9), m_sat9);
            if (m_hold) begin
                chk("acc_out", int'(acc_out), m_out12);
                chk("acc_out9", int'(acc_out9), m_out9);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int p);
        tick();
        prod_in    = 8'(p);
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    initial begin
        int exp9, exps9;
        rst_n = 1'b0; prod_in = '0; prod_valid = 1'b0; clear = 1'b0; acc_ready = 1'b1;
        #12;
        chk("reset_acc_out", int'(acc_out), 0);
        chk("reset_acc_valid", int'(acc_valid), 0);
        chk("reset_term_cnt", int'(term_cnt), 0);
        chk("reset_drop_err", int'(drop_err), 0);
        chk("reset_acc_sat", int'(acc_sat), 0);
        rst_n = 1'b1;

        // 1: four edges, result one cycle after the last
        pulse(12); pulse(25); pulse(225); pulse(1);
        @(negedge clk);
        chk("t1_valid", int'(acc_valid), 1);
        chk("t1_out", int'(acc_out), 263);
        chk("t1_model", m_out12, 263);

        // 2: a held level counts once
        tick(); prod_in = 8'd9; prod_valid = 1'b1;
        repeat (10) tick();
        prod_valid = 1'b0;
        pulse(1); pulse(1); pulse(1);
        @(negedge clk);
        chk("t2_out", int'(acc_out), 12);
        chk("t2_valid", int'(acc_valid), 1);

        // 3: stalled output, pending fills then overflows
        tick(); acc_ready = 1'b0;
        pulse(1); pulse(2); pulse(3); pulse(4);
        pulse(50); pulse(7);
        @(negedge clk);
        chk("t3_drop", int'(drop_err), 1);
        chk("t3_out_held", int'(acc_out), 10);
        tick(); acc_ready = 1'b1;
        tick(); acc_ready = 1'b0;
        @(negedge clk);
        chk("t3_cnt_after_hs", int'(term_cnt), 1);
        chk("t3_valid_after_hs", int'(acc_valid), 0);
        pulse(1); pulse(1); pulse(1);
        @(negedge clk);
        chk("t3_out", int'(acc_out), 53);

        // 4: handshake and new edge together with a full pending register
        pulse(30);
        tick(); acc_ready = 1'b1; prod_in = 8'd4; prod_valid = 1'b1;
        tick(); acc_ready = 1'b0; prod_valid = 1'b0;
        @(negedge clk);
        chk("t4_cnt", int'(term_cnt), 1);
        @(negedge clk);
        chk("t4_cnt_drain", int'(term_cnt), 2);

        // 5: clear mid-accumulation, then a fresh result; then async reset mid-sum
        tick(); clear = 1'b1;
        tick(); clear = 1'b0;
        @(negedge clk);
        chk("t5_clear_cnt", int'(term_cnt), 0);
        chk("t5_clear_drop", int'(drop_err), 0);
        acc_ready = 1'b1;
        pulse(1); pulse(1); pulse(1); pulse(1);
        @(negedge clk);
        chk("t5_out", int'(acc_out), 4);
        pulse(2); pulse(2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cnt", int'(term_cnt), 0);
        chk("t5_rst_valid", int'(acc_valid), 0);
        #10 rst_n = 1'b1;
        pulse(1); pulse(1); pulse(1); pulse(1);
        @(negedge clk);
        chk("t5_rst_out", int'(acc_out), 4);

        // 6: overflow of the narrow instance
        pulse(225); pulse(225); pulse(225); pulse(225);
`ifdef MACC_SAT_EN
        exp9 = 511; exps9 = 1;
`else
        exp9 = 388; exps9 = 0;
`endif
        @(negedge clk);
        chk("t6_out9", int'(acc_out9), exp9);
        chk("t6_sat9", int'(acc_sat9), exps9);
        chk("t6_model9", m_out9, exp9);
        chk("t6_out12", int'(acc_out), 900);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            prod_valid = 1'($urandom_range(0, 1));
            prod_in    = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            acc_ready  = ($urandom_range(0, 3) != 0);
            clear      = ($urandom_range(0, 99) == 0);
        end
        tick(); clear = 1'b0; prod_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
